// File: rtl/clock_pkg.sv
// Shared definitions for the clock display path.
// Holds the digit count, active-low 7-segment patterns ({g,f,e,d,c,b,a}),
// the "all anodes off" value, the scan position enumeration and two small
// helpers: position sequencing and position-to-anode decode.
package clock_pkg;

    localparam int NUM_DIGITS = 6;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0    = 7'h40;
    localparam logic [6:0] SEG_1    = 7'h79;
    localparam logic [6:0] SEG_2    = 7'h24;
    localparam logic [6:0] SEG_3    = 7'h30;
    localparam logic [6:0] SEG_4    = 7'h19;
    localparam logic [6:0] SEG_5    = 7'h12;
    localparam logic [6:0] SEG_6    = 7'h02;
    localparam logic [6:0] SEG_7    = 7'h78;
    localparam logic [6:0] SEG_8    = 7'h00;
    localparam logic [6:0] SEG_9    = 7'h10;
    localparam logic [6:0] SEG_DASH = 7'h3F;
    localparam logic [6:0] SEG_OFF  = 7'h7F;

    localparam logic [5:0] AN_OFF   = 6'h3F;

    typedef enum logic [2:0] {
        POS_SEC_ONES = 3'd0,
        POS_SEC_TENS = 3'd1,
        POS_MIN_ONES = 3'd2,
        POS_MIN_TENS = 3'd3,
        POS_HR_ONES  = 3'd4,
        POS_HR_TENS  = 3'd5
    } pos_t;

    // Scan order 0 -> 1 -> ... -> 5 -> 0; an illegal code recovers to 0
    function automatic pos_t pos_next(input pos_t p);
        pos_t n;
        case (p)
            POS_SEC_ONES: n = POS_SEC_TENS;
            POS_SEC_TENS: n = POS_MIN_ONES;
            POS_MIN_ONES: n = POS_MIN_TENS;
            POS_MIN_TENS: n = POS_HR_ONES;
            POS_HR_ONES:  n = POS_HR_TENS;
            POS_HR_TENS:  n = POS_SEC_ONES;
            default:      n = POS_SEC_ONES;
        endcase
        return n;
    endfunction

    // One active-low anode per position; an illegal code lights nothing
    function automatic logic [5:0] pos_anode(input pos_t p);
        logic [5:0] a;
        case (p)
            POS_SEC_ONES: a = 6'b111110;
            POS_SEC_TENS: a = 6'b111101;
            POS_MIN_ONES: a = 6'b111011;
            POS_MIN_TENS: a = 6'b110111;
            POS_HR_ONES:  a = 6'b101111;
            POS_HR_TENS:  a = 6'b011111;
            default:      a = AN_OFF;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/clock_display_scan_bcd_to_seg7.sv
// bcd_to_seg7: combinational BCD to active-low 7-segment decoder.
// Ports:
//   bcd  in  4  digit value; 0-9 decode normally, 10-15 show a dash
//   seg  out 7  segments {g,f,e,d,c,b,a}, active-low
module bcd_to_seg7
    import clock_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Digit lookup; non-BCD codes fall through to the dash pattern
    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/clock_display_scan.sv
// clock_display_scan: six-digit multiplexed common-anode display driver for
// an HH:MM:SS clock. All six digits are captured into a shadow register once
// per frame so a digit never changes while the frame is being scanned.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   en             scan enable; 0 blanks the display and freezes the scan
//   sec_ones..hr_tens  BCD time digits from the time counter
//   an             active-low digit anodes, bit k = position k
//   seg            active-low segments {g,f,e,d,c,b,a}
//   dp             active-low decimal point (blinking colon at positions 2, 4)
//   frame_start    one-cycle pulse the cycle after a frame load
module clock_display_scan
    import clock_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] sec_ones,
    input  logic [2:0] sec_tens,
    input  logic [3:0] min_ones,
    input  logic [2:0] min_tens,
    input  logic [3:0] hr_ones,
    input  logic [1:0] hr_tens,
    output logic [5:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_start
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PCNT_LAST = PW'(SCAN_DIV - 1);

    logic [PW-1:0]                 pcnt_r;
    pos_t                          idx_r;
    logic [NUM_DIGITS-1:0][3:0]    shadow_r;
    logic [5:0]                    an_r;
    logic [6:0]                    seg_r;
    logic                          dp_r;
    logic                          frame_start_r;

    logic                          tc_s;
    logic                          wrap_s;
    logic [3:0]                    digit_s;
    logic [6:0]                    dec_seg_s;
    logic [6:0]                    seg_next_s;
    logic                          dp_next_s;

    assign tc_s   = (pcnt_r == PCNT_LAST);
    assign wrap_s = tc_s && (idx_r == POS_HR_TENS);

    // Prescaler, position counter and frame snapshot. Reset parks the scan on
    // the last count of position 5 so the first enabled cycle loads a frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt_r   <= PCNT_LAST;
            idx_r    <= POS_HR_TENS;
            shadow_r <= '0;
        end else if (en) begin
            if (tc_s) begin
                pcnt_r <= '0;
                idx_r  <= pos_next(idx_r);
                if (wrap_s) begin
                    shadow_r <= {{2'b00, hr_tens}, hr_ones,
                                 {1'b0, min_tens}, min_ones,
                                 {1'b0, sec_tens}, sec_ones};
                end
            end else begin
                pcnt_r <= pcnt_r + PW'(1);
            end
        end
    end

    // Select the shadow digit for the current position
    always_comb begin
        digit_s = 4'd0;
        case (idx_r)
            POS_SEC_ONES: digit_s = shadow_r[0];
            POS_SEC_TENS: digit_s = shadow_r[1];
            POS_MIN_ONES: digit_s = shadow_r[2];
            POS_MIN_TENS: digit_s = shadow_r[3];
            POS_HR_ONES:  digit_s = shadow_r[4];
            POS_HR_TENS:  digit_s = shadow_r[5];
            default:      digit_s = 4'd0;
        endcase
    end

    bcd_to_seg7 u_bcd_to_seg7 (
        .bcd (digit_s),
        .seg (dec_seg_s)
    );

    // Leading hour zero blanking and colon: the colon dots sit after the
    // minutes-ones and hours-ones digits and blink with the seconds LSB.
    always_comb begin
        seg_next_s = dec_seg_s;
        dp_next_s  = 1'b1;
        if (BLANK_LZ && (idx_r == POS_HR_TENS) && (digit_s == 4'd0)) begin
            seg_next_s = SEG_OFF;
        end else begin
            seg_next_s = dec_seg_s;
        end
        if (((idx_r == POS_MIN_ONES) || (idx_r == POS_HR_ONES)) &&
            (shadow_r[0][0] == 1'b0)) begin
            dp_next_s = 1'b0;
        end else begin
            dp_next_s = 1'b1;
        end
    end

    // Output registers: one cycle behind the position counter, dark when
    // disabled or in reset
    always_ff @(posedge clk) begin
        if (rst) begin
            an_r          <= AN_OFF;
            seg_r         <= SEG_OFF;
            dp_r          <= 1'b1;
            frame_start_r <= 1'b0;
        end else if (en) begin
            an_r          <= pos_anode(idx_r);
            seg_r         <= seg_next_s;
            dp_r          <= dp_next_s;
            frame_start_r <= wrap_s;
        end else begin
            an_r          <= AN_OFF;
            seg_r         <= SEG_OFF;
            dp_r          <= 1'b1;
            frame_start_r <= 1'b0;
        end
    end

    assign an          = an_r;
    assign seg         = seg_r;
    assign dp          = dp_r;
    assign frame_start = frame_start_r;

endmodule

// File: tb/tb_clock_display_scan.sv
// Bench for clock_display_scan: hand-derived frame vectors, a per-cycle
// scoreboard for a SCAN_DIV=4 and a SCAN_DIV=1 instance, and a few
// multi-cycle sequences (mid-frame change, enable gap, reset mid-frame).
module tb_clock_display_scan;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b1;
    logic [3:0] sec_ones = 4'd0;
    logic [2:0] sec_tens = 3'd0;
    logic [3:0] min_ones = 4'd0;
    logic [2:0] min_tens = 3'd0;
    logic [3:0] hr_ones  = 4'd0;
    logic [1:0] hr_tens  = 2'd0;

    logic [5:0] an_a, an_b;
    logic [6:0] seg_a, seg_b;
    logic       dp_a, dp_b, fs_a, fs_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    clock_display_scan #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dut_a (
        .clk(clk), .rst(rst), .en(en),
        .sec_ones(sec_ones), .sec_tens(sec_tens),
        .min_ones(min_ones), .min_tens(min_tens),
        .hr_ones(hr_ones), .hr_tens(hr_tens),
        .an(an_a), .seg(seg_a), .dp(dp_a), .frame_start(fs_a)
    );

    clock_display_scan #(.SCAN_DIV(1), .BLANK_LZ(1'b1)) dut_b (
        .clk(clk), .rst(rst), .en(en),
        .sec_ones(sec_ones), .sec_tens(sec_tens),
        .min_ones(min_ones), .min_tens(min_tens),
        .hr_ones(hr_ones), .hr_tens(hr_tens),
        .an(an_b), .seg(seg_b), .dp(dp_b), .frame_start(fs_b)
    );

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard model ----------------
    typedef struct packed {
        logic [5:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fs;
    } obs_t;

    typedef struct {
        int          pcnt;
        int          idx;
        logic [23:0] sh;
        obs_t        o;
    } model_t;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0: s = 7'h40;  4'd1: s = 7'h79;  4'd2: s = 7'h24;  4'd3: s = 7'h30;
            4'd4: s = 7'h19;  4'd5: s = 7'h12;  4'd6: s = 7'h02;  4'd7: s = 7'h78;
            4'd8: s = 7'h00;  4'd9: s = 7'h10;
            default: s = 7'h3F;
        endcase
        return s;
    endfunction

    function automatic model_t mstep(input model_t s, input logic r, input logic e,
                                     input logic [23:0] d, input int sd);
        model_t     n;
        logic [3:0] dig;
        n = s;
        if (r) begin
            n.pcnt = sd - 1;
            n.idx  = 5;
            n.sh   = 24'd0;
            n.o    = '{an: 6'h3F, seg: 7'h7F, dp: 1'b1, fs: 1'b0};
        end else if (!e) begin
            n.o    = '{an: 6'h3F, seg: 7'h7F, dp: 1'b1, fs: 1'b0};
        end else begin
            dig       = s.sh[s.idx*4 +: 4];
            n.o.an    = ~(6'd1 << s.idx);
            n.o.seg   = (s.idx == 5 && dig == 4'd0) ? 7'h7F : seg_of(dig);
            n.o.dp    = ((s.idx == 2 || s.idx == 4) && !s.sh[0]) ? 1'b0 : 1'b1;
            n.o.fs    = 1'b0;
            if (s.pcnt == sd - 1) begin
                n.pcnt = 0;
                if (s.idx == 5) begin
                    n.idx  = 0;
                    n.sh   = d;
                    n.o.fs = 1'b1;
                end else begin
                    n.idx = s.idx + 1;
                end
            end else begin
                n.pcnt = s.pcnt + 1;
            end
        end
        return n;
    endfunction

    logic [23:0] din_s;
    assign din_s = {2'b00, hr_tens, hr_ones, 1'b0, min_tens, min_ones, 1'b0, sec_tens, sec_ones};

    bit     sb_on = 1'b0;
    model_t ma, mb;
    obs_t   q_a[$];
    obs_t   q_b[$];

    // Advance both models on each clock and queue the expected outputs
    always @(posedge clk) begin
        if (sb_on) begin
            ma = mstep(ma, rst, en, din_s, 4);
            mb = mstep(mb, rst, en, din_s, 1);
            q_a.push_back(ma.o);
            q_b.push_back(mb.o);
        end
    end

    // Compare DUT outputs against queued expectations away from the clock edge
    always @(negedge clk) begin
        obs_t ea, eb;
        if (q_a.size() > 0) begin
            ea = q_a.pop_front();
            chk("sb_a", 16'({an_a, seg_a, dp_a, fs_a}), 16'(ea));
        end
        if (q_b.size() > 0) begin
            eb = q_b.pop_front();
            chk("sb_b", 16'({an_b, seg_b, dp_b, fs_b}), 16'(eb));
        end
    end

    // ---------------- vectors ----------------
    typedef struct {
        logic [3:0]      s1;
        logic [2:0]      s10;
        logic [3:0]      m1;
        logic [2:0]      m10;
        logic [3:0]      h1;
        logic [1:0]      h10;
        logic [5:0][6:0] seg;
        logic [5:0]      dp;
    } vec_t;

    vec_t vecs[6];

    task automatic set_time(input vec_t v);
        sec_ones = v.s1;  sec_tens = v.s10;
        min_ones = v.m1;  min_tens = v.m10;
        hr_ones  = v.h1;  hr_tens  = v.h10;
    endtask

    task automatic wait_fs(input string nm);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (fs_a !== 1'b1 && n < 40);
        chk(nm, 16'(fs_a), 16'd1);
    endtask

    task automatic wait_an(input string nm, input logic [5:0] target);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (an_a !== target && n < 40);
        chk(nm, 16'(an_a), 16'(target));
    endtask

    initial begin
        int         cnt;
        logic [5:0] exp_an;

        vecs[0] = '{4'd6, 3'd5, 4'd4, 3'd3, 4'd2, 2'd1,
                    {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02}, 6'b101011};
        vecs[1] = '{4'd8, 3'd0, 4'd5, 3'd0, 4'd9, 2'd0,
                    {7'h7F, 7'h10, 7'h40, 7'h12, 7'h40, 7'h00}, 6'b101011};
        vecs[2] = '{4'd7, 3'd5, 4'd4, 3'd3, 4'd2, 2'd1,
                    {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h78}, 6'b111111};
        vecs[3] = '{4'd12, 3'd5, 4'd4, 3'd3, 4'd2, 2'd1,
                    {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h3F}, 6'b101011};
        vecs[4] = '{4'd9, 3'd5, 4'd9, 3'd5, 4'd3, 2'd2,
                    {7'h24, 7'h30, 7'h12, 7'h10, 7'h12, 7'h10}, 6'b111111};
        vecs[5] = '{4'd0, 3'd0, 4'd0, 3'd0, 4'd0, 2'd1,
                    {7'h79, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}, 6'b101011};

        // Reset state
        set_time(vecs[0]);
        rst = 1'b1;
        en  = 1'b1;
        @(negedge clk);
        sb_on = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_an",  16'(an_a),  16'h003F);
        chk("reset_seg", 16'(seg_a), 16'h007F);
        chk("reset_dp",  16'(dp_a),  16'd1);
        chk("reset_fs",  16'(fs_a),  16'd0);

        // First enabled cycle loads a frame
        rst = 1'b0;
        @(negedge clk);
        chk("first_fs_a", 16'(fs_a), 16'd1);
        chk("first_fs_b", 16'(fs_b), 16'd1);
        @(negedge clk);
        chk("first_pos0_an",  16'(an_a),  16'h003E);
        chk("first_pos0_seg", 16'(seg_a), 16'h0002);
        chk("first_fs_low",   16'(fs_a),  16'd0);

        // Table-driven frames
        for (int i = 0; i < 6; i++) begin
            set_time(vecs[i]);
            wait_fs("vec_fs");
            for (int p = 0; p < 6; p++) begin
                @(negedge clk);
                exp_an = ~(6'd1 << p);
                chk("vec_an",  16'(an_a),  16'(exp_an));
                chk("vec_seg", 16'(seg_a), 16'(vecs[i].seg[p]));
                chk("vec_dp",  16'(dp_a),  16'(vecs[i].dp[p]));
                repeat (3) @(negedge clk);
            end
        end

        // Mid-frame input change is held off until the next frame
        set_time(vecs[0]);
        wait_fs("mid_fs0");
        repeat (8) @(negedge clk);
        set_time(vecs[2]);
        @(negedge clk);
        chk("mid_old_dp2", 16'(dp_a), 16'd0);
        repeat (8) @(negedge clk);
        chk("mid_old_an4",  16'(an_a),  16'h002F);
        chk("mid_old_seg4", 16'(seg_a), 16'h0024);
        chk("mid_old_dp4",  16'(dp_a),  16'd0);
        wait_fs("mid_fs1");
        @(negedge clk);
        chk("mid_new_seg0", 16'(seg_a), 16'h0078);
        repeat (8) @(negedge clk);
        chk("mid_new_an2", 16'(an_a), 16'h003B);
        chk("mid_new_dp2", 16'(dp_a), 16'd1);

        // Enable gap in the middle of position 3
        wait_an("gap_reach3", 6'b110111);
        cnt = 1;
        @(negedge clk);
        if (an_a == 6'b110111) cnt++;
        en = 1'b0;
        @(negedge clk);
        chk("gap_dark_an",  16'(an_a),  16'h003F);
        chk("gap_dark_seg", 16'(seg_a), 16'h007F);
        chk("gap_dark_dp",  16'(dp_a),  16'd1);
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (an_a == 6'b110111) cnt++;
            if (i == 8) en = 1'b1;
        end
        chk("gap_pos3_cycles", 16'(cnt), 16'd4);

        // Reset at position 4, then both instances restart with a frame load
        wait_an("rst_reach4", 6'b101111);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_an",  16'(an_a),  16'h003F);
        chk("rst_mid_seg", 16'(seg_a), 16'h007F);
        chk("rst_mid_dp",  16'(dp_a),  16'd1);
        chk("rst_mid_fs",  16'(fs_a),  16'd0);
        chk("rst_mid_an_b", 16'(an_b), 16'h003F);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_rel_fs_a", 16'(fs_a), 16'd1);
        chk("rst_rel_fs_b", 16'(fs_b), 16'd1);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            exp_an = ~(6'd1 << (k % 6));
            chk("div1_an", 16'(an_b), 16'(exp_an));
        end

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
